// File: rtl/rename_rewind_ctrl_pkg.sv
// Shared types and sizing for the rename rewind controller.
// ROB index width, physical register width and the walk FSM encoding live here.
package rename_rewind_ctrl_pkg;

  localparam int ROB_W     = 5;
  localparam int PR_W      = 6;
  localparam int ARCH_W    = 5;
  localparam int LANES     = 3;
  localparam int ROB_DEPTH = 1 << ROB_W;

  typedef logic [ROB_W-1:0]  rob_idx_t;
  typedef logic [PR_W-1:0]   preg_t;
  typedef logic [ARCH_W-1:0] arch_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } rw_state_e;

endpackage

// File: rtl/rename_rewind_ctrl_if.sv
// Recovery request, ROB read port and rename-side restore bundle.
// master = core/ROB/map-table side, slave = the rewind controller.
interface rename_rewind_ctrl_if;
  import rename_rewind_ctrl_pkg::*;

  logic                            recover_req;
  rob_idx_t                        recover_rob_idx;
  rob_idx_t                        rob_tail;

  logic [LANES-1:0][ROB_W-1:0]     rob_rd_idx;
  logic [LANES-1:0]                rob_rd_dest_valid;
  logic [LANES-1:0][PR_W-1:0]      rob_rd_t;
  logic [LANES-1:0][PR_W-1:0]      rob_rd_told;
  logic [LANES-1:0][ARCH_W-1:0]    rob_rd_arch;

  logic [LANES-1:0]                RewindEN;
  logic [LANES-1:0][PR_W-1:0]      RewindReg;

  logic [LANES-1:0]                map_restore_en;
  logic [LANES-1:0][ARCH_W-1:0]    map_restore_arch;
  logic [LANES-1:0][PR_W-1:0]      map_restore_pr;

  logic                            rob_tail_restore_en;
  rob_idx_t                        rob_tail_restore;
  logic                            dispatch_stall;
  logic                            recover_done;

  modport master (
    output recover_req, recover_rob_idx, rob_tail,
    output rob_rd_dest_valid, rob_rd_t, rob_rd_told, rob_rd_arch,
    input  rob_rd_idx,
    input  RewindEN, RewindReg,
    input  map_restore_en, map_restore_arch, map_restore_pr,
    input  rob_tail_restore_en, rob_tail_restore, dispatch_stall, recover_done
  );

  modport slave (
    input  recover_req, recover_rob_idx, rob_tail,
    input  rob_rd_dest_valid, rob_rd_t, rob_rd_told, rob_rd_arch,
    output rob_rd_idx,
    output RewindEN, RewindReg,
    output map_restore_en, map_restore_arch, map_restore_pr,
    output rob_tail_restore_en, rob_tail_restore, dispatch_stall, recover_done
  );

endinterface

// File: rtl/rename_rewind_ctrl_rewind_window.sv
// Walk-window sizing: how many ROB entries between ptr (inclusive) and stop
// (exclusive) are undone this cycle, capped at the lane count.
module rewind_window
  import rename_rewind_ctrl_pkg::*;
(
  input  rob_idx_t         ptr_i,
  input  rob_idx_t         stop_i,
  output logic [1:0]       cnt_o,
  output logic [LANES-1:0] lane_vld_o,
  output logic             last_o
);

  rob_idx_t rem;

  // Plain ROB_W-bit subtraction gives the modulo distance, including across 0.
  assign rem    = ptr_i - stop_i;
  assign last_o = (rem <= rob_idx_t'(LANES));
  assign cnt_o  = last_o ? rem[1:0] : 2'(LANES);

  always_comb begin
    lane_vld_o = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_vld_o[k] = (2'(k) < cnt_o);
    end
  end

endmodule

// File: rtl/rename_rewind_ctrl.sv
// Branch-mispredict rename rollback: walks the ROB from the tail back to the
// mispredicted branch, up to three entries per cycle, then restores the tail.
module rename_rewind_ctrl
  import rename_rewind_ctrl_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  rename_rewind_ctrl_if.slave  bus
);

  rw_state_e state_q, state_d;
  rob_idx_t  ptr_q, ptr_d;
  rob_idx_t  stop_q, stop_d;

  logic [1:0]       win_cnt;
  logic [LANES-1:0] win_vld;
  logic             win_last;
  rob_idx_t         req_ptr;
  logic             walk_active;

  logic                         stall;
  logic                         tail_en;
  rob_idx_t                     tail_val;
  logic                         done;
  logic [LANES-1:0][ROB_W-1:0]  rd_idx;
  logic [LANES-1:0]             lane_en;
  logic [LANES-1:0][PR_W-1:0]   rew_reg;
  logic [LANES-1:0][ARCH_W-1:0] rst_arch;
  logic [LANES-1:0][PR_W-1:0]   rst_pr;

  rewind_window u_window (
    .ptr_i      (ptr_q),
    .stop_i     (stop_q),
    .cnt_o      (win_cnt),
    .lane_vld_o (win_vld),
    .last_o     (win_last)
  );

  assign req_ptr     = bus.rob_tail - 1'b1;
  assign walk_active = (state_q == ST_WALK);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      stop_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    stop_d   = stop_q;
    stall    = 1'b0;
    tail_en  = 1'b0;
    tail_val = '0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stall = bus.recover_req;
        if (bus.recover_req) begin
          stop_d  = bus.recover_rob_idx;
          ptr_d   = req_ptr;
          // Nothing younger than the branch: skip straight to the tail restore.
          state_d = (req_ptr != bus.recover_rob_idx) ? ST_WALK : ST_DONE;
        end
      end
      ST_WALK: begin
        stall = 1'b1;
        ptr_d = ptr_q - rob_idx_t'(win_cnt);
        if (win_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        stall    = 1'b1;
        tail_en  = 1'b1;
        tail_val = stop_q + 1'b1;
        done     = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read addresses depend only on state, so the ROB can answer in-cycle.
  always_comb begin
    rd_idx = '0;
    if (walk_active) begin
      for (int k = 0; k < LANES; k++) begin
        rd_idx[k] = ptr_q - rob_idx_t'(k);
      end
    end
  end

  always_comb begin
    lane_en  = '0;
    rew_reg  = '0;
    rst_arch = '0;
    rst_pr   = '0;
    if (walk_active) begin
      for (int k = 0; k < LANES; k++) begin
        lane_en[k]  = win_vld[k] & bus.rob_rd_dest_valid[k];
        rew_reg[k]  = bus.rob_rd_t[k];
        rst_arch[k] = bus.rob_rd_arch[k];
        rst_pr[k]   = bus.rob_rd_told[k];
      end
    end
  end

  assign bus.rob_rd_idx          = rd_idx;
  assign bus.RewindEN            = lane_en;
  assign bus.RewindReg           = rew_reg;
  assign bus.map_restore_en      = lane_en;
  assign bus.map_restore_arch    = rst_arch;
  assign bus.map_restore_pr      = rst_pr;
  assign bus.rob_tail_restore_en = tail_en;
  assign bus.rob_tail_restore    = tail_val;
  assign bus.dispatch_stall      = stall;
  assign bus.recover_done        = done;

endmodule
